// File: rtl/seq_mult_bcd_disp_if.sv
// Operand/result bundle for seq_mult_bcd_disp: the start/busy/done handshake plus result outputs.
// The master issues start with a/b; the slave answers with busy, a one-cycle done and held results.
interface seq_mult_bcd_disp_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  busy;
    logic                  done;
    logic [2*WIDTH-1:0]    product;
    logic [7*DIGITS-1:0]   seg;

    modport master (
        output start, a, b,
        input  busy, done, product, seg
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, seg
    );
endinterface

// File: rtl/seq_mult_bcd_disp.sv
// Sequential shift-add multiplier followed by a double-dabble BCD converter driving DIGITS
// 7-segment digits. Handshake: start is taken only in IDLE; busy covers MULT..DONE; done pulses once.
module seq_mult_bcd_disp #(
    parameter int WIDTH          = 4,
    parameter int DIGITS         = 3,
    parameter int BLANK_LZ       = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_mult_bcd_disp_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(PW + 1);

    function automatic int dec_digits(input int w);
        logic [127:0] v;
        int           n;
        v = (128'd1 << w) - 128'd1;
        v = v * v;
        n = 1;
        v = v / 128'd10;
        while (v != 128'd0) begin
            n++;
            v = v / 128'd10;
        end
        return n;
    endfunction

    localparam int NEED_DIGITS = dec_digits(WIDTH);

    generate
        if (DIGITS < NEED_DIGITS) begin : g_digits_check
            $error("seq_mult_bcd_disp: DIGITS too small for the largest WIDTH-bit product");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MULT, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_sum;
    logic [PW-1:0]   bin_q;
    logic [BW-1:0]   bcd_q;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_shift;
    logic [PW-1:0]   product_q;
    logic [BW-1:0]   disp_q;
    logic [7*DIGITS-1:0] seg_d;
    logic            lead;
    logic [3:0]      nib;
    logic [6:0]      raw;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = MULT;
            MULT:    if (cnt_q == CW'(WIDTH - 1)) state_d = CONV;
            CONV:    if (cnt_q == CW'(PW - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[BW-2:0], bin_q[PW-1]};
    end

    // Result registers load only on the last conversion step, so outputs never show partial values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            product_q <= '0;
            disp_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, bus.a};
                        mplier_q <= bus.b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                MULT: begin
                    acc_q    <= acc_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_q <= '0;
                        bin_q <= acc_sum;
                        bcd_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                CONV: begin
                    bcd_q <= bcd_shift;
                    bin_q <= bin_q << 1;
                    if (cnt_q == CW'(PW - 1)) begin
                        cnt_q     <= '0;
                        product_q <= acc_q;
                        disp_q    <= bcd_shift;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Walk from the most significant digit down; lead stays set while only zeros have been seen.
    always_comb begin
        seg_d = '0;
        lead  = 1'b1;
        nib   = '0;
        raw   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = disp_q[4*k +: 4];
            if (nib != 4'd0) lead = 1'b0;
            raw = ((BLANK_LZ != 0) && lead && (k != 0)) ? 7'b0000000 : seg7(nib);
            seg_d[7*k +: 7] = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
    assign bus.seg     = seg_d;
endmodule

// File: tb/tb_seq_mult_bcd_disp.sv
// Scoreboard bench for seq_mult_bcd_disp: three instances (plain, leading-zero blanking, 8-bit
// active-low) with directed operands; expected product, digits and done cycle are queued at issue.
module tb_seq_mult_bcd_disp;
    localparam int EW = 64;

    localparam logic [6:0] SEG_TAB [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [EW-1:0] exp0_q[$];
    logic [EW-1:0] exp1_q[$];
    logic [EW-1:0] exp2_q[$];
    int            cyc0_q[$];
    int            cyc1_q[$];
    int            cyc2_q[$];

    // Directed vectors: a, b, product and its decimal digits written as BCD.
    logic [3:0]  va   [0:8] = '{4'd0, 4'd15, 4'd15, 4'd9, 4'd6, 4'd4, 4'd7, 4'd10, 4'd3};
    logic [3:0]  vb   [0:8] = '{4'd0, 4'd1,  4'd15, 4'd8, 4'd9, 4'd7, 4'd7, 4'd10, 4'd3};
    logic [7:0]  vp   [0:8] = '{8'd0, 8'd15, 8'd225, 8'd72, 8'd54, 8'd28, 8'd49, 8'd100, 8'd9};
    logic [19:0] vbcd [0:8] = '{20'h0, 20'h15, 20'h225, 20'h72, 20'h54, 20'h28, 20'h49, 20'h100, 20'h9};

    logic [7:0]  wa   [0:3] = '{8'd255, 8'd0, 8'd200, 8'd12};
    logic [7:0]  wb   [0:3] = '{8'd255, 8'd0, 8'd150, 8'd12};
    logic [15:0] wp   [0:3] = '{16'd65025, 16'd0, 16'd30000, 16'd144};
    logic [19:0] wbcd [0:3] = '{20'h65025, 20'h0, 20'h30000, 20'h144};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mult_bcd_disp_if #(.WIDTH(4), .DIGITS(3)) if0 ();
    seq_mult_bcd_disp_if #(.WIDTH(4), .DIGITS(3)) if1 ();
    seq_mult_bcd_disp_if #(.WIDTH(8), .DIGITS(5)) if2 ();

    assign if1.start = if0.start;
    assign if1.a     = if0.a;
    assign if1.b     = if0.b;

    seq_mult_bcd_disp #(.WIDTH(4), .DIGITS(3), .BLANK_LZ(0), .SEG_ACTIVE_LOW(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    seq_mult_bcd_disp #(.WIDTH(4), .DIGITS(3), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );
    seq_mult_bcd_disp #(.WIDTH(8), .DIGITS(5), .BLANK_LZ(0), .SEG_ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2)
    );

    function automatic logic [34:0] seg_of(input logic [19:0] bcd, input int n,
                                           input bit blank, input bit inv);
        logic [34:0] r;
        bit          lead;
        logic [3:0]  d;
        logic [6:0]  s;
        r    = '0;
        lead = 1'b1;
        for (int k = n - 1; k >= 0; k--) begin
            d = bcd[4*k +: 4];
            if (d != 4'd0) lead = 1'b0;
            s = (blank && lead && k != 0) ? 7'b0000000 : SEG_TAB[d];
            if (inv) s = ~s;
            r[7*k +: 7] = s;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one op to dut0/dut1 at a negedge while they are IDLE; hold keeps start high with new a/b.
    task automatic issue0(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p,
                          input logic [19:0] bcd, input bit push, input int hold);
        logic [34:0] s0, s1;
        s0 = seg_of(bcd, 3, 1'b0, 1'b0);
        s1 = seg_of(bcd, 3, 1'b1, 1'b0);
        if0.start = 1'b1;
        if0.a     = a;
        if0.b     = b;
        if (push) begin
            exp0_q.push_back(EW'({p, s0[20:0]}));
            exp1_q.push_back(EW'({p, s1[20:0]}));
            cyc0_q.push_back(cyc + 13);
            cyc1_q.push_back(cyc + 13);
        end
        @(negedge clk);
        check("busy_after_accept", EW'(if0.busy), EW'(1'b1));
        if (hold > 0) begin
            if0.a = ~a;
            if0.b = ~b;
            repeat (hold) @(negedge clk);
        end
        if0.start = 1'b0;
    endtask

    task automatic issue2(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                          input logic [19:0] bcd);
        logic [34:0] s;
        s = seg_of(bcd, 5, 1'b0, 1'b1);
        if2.start = 1'b1;
        if2.a     = a;
        if2.b     = b;
        exp2_q.push_back(EW'({p, s}));
        cyc2_q.push_back(cyc + 25);
        @(negedge clk);
        if2.start = 1'b0;
    endtask

    task automatic wait_done(input int which);
        int n;
        n = 0;
        while (((which == 0) ? if0.done : if2.done) !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: dut%0d done not seen within %0d cycles", which, n);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && if0.done === 1'b1) begin
            if (exp0_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut0_spurious_done: done=1 with no result expected (t=%0t)", $time);
            end else begin
                check("dut0_result", EW'({if0.product, if0.seg}), exp0_q.pop_front());
                check("dut0_latency", EW'(cyc), EW'(cyc0_q.pop_front()));
                check("dut0_busy_at_done", EW'(if0.busy), EW'(1'b1));
            end
        end
        if (rst_n === 1'b1 && if1.done === 1'b1) begin
            if (exp1_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut1_spurious_done: done=1 with no result expected (t=%0t)", $time);
            end else begin
                check("dut1_result", EW'({if1.product, if1.seg}), exp1_q.pop_front());
                check("dut1_latency", EW'(cyc), EW'(cyc1_q.pop_front()));
            end
        end
        if (rst_n === 1'b1 && if2.done === 1'b1) begin
            if (exp2_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut2_spurious_done: done=1 with no result expected (t=%0t)", $time);
            end else begin
                check("dut2_result", EW'({if2.product, if2.seg}), exp2_q.pop_front());
                check("dut2_latency", EW'(cyc), EW'(cyc2_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if0.start = 1'b0; if0.a = '0; if0.b = '0;
        if2.start = 1'b0; if2.a = '0; if2.b = '0;

        // Reset held for two edges
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", EW'(if0.busy), EW'(1'b0));
        check("rst_done", EW'(if0.done), EW'(1'b0));
        check("rst_product", EW'(if0.product), EW'(0));
        check("rst_seg", EW'(if0.seg), EW'({7'b1111110, 7'b1111110, 7'b1111110}));
        check("rst_seg_blank", EW'(if1.seg), EW'({7'b0000000, 7'b0000000, 7'b1111110}));
        check("rst_seg_w8_inv", EW'(if2.seg), EW'({5{7'b0000001}}));
        check("rst_product_w8", EW'(if2.product), EW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed products
        for (int i = 0; i < 9; i++) begin
            issue0(va[i], vb[i], vp[i], vbcd[i], 1'b1, 0);
            wait_done(0);
            @(negedge clk);
        end

        // start held high, then pulsed mid-operation with other operands: both ignored
        issue0(4'd5, 4'd3, 8'd15, 20'h15, 1'b1, 4);
        repeat (2) @(negedge clk);
        if0.start = 1'b1; if0.a = 4'd9; if0.b = 4'd9;
        @(negedge clk);
        if0.start = 1'b0;
        wait_done(0);
        @(negedge clk);
        // Back-to-back: accepted in the IDLE cycle right after done
        issue0(4'd2, 4'd3, 8'd6, 20'h6, 1'b1, 0);
        wait_done(0);
        @(negedge clk);

        // Reset during cycle 5 of an op: no done, outputs back to reset values
        issue0(4'd15, 4'd15, 8'd225, 20'h225, 1'b0, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", EW'(if0.busy), EW'(1'b0));
        check("abort_done", EW'(if0.done), EW'(1'b0));
        check("abort_product", EW'(if0.product), EW'(0));
        check("abort_seg", EW'(if0.seg), EW'({7'b1111110, 7'b1111110, 7'b1111110}));
        check("abort_seg_blank", EW'(if1.seg), EW'({7'b0000000, 7'b0000000, 7'b1111110}));
        repeat (20) @(negedge clk);
        check("abort_still_idle", EW'(if0.busy), EW'(1'b0));

        // 8-bit, 5-digit, active-low instance
        for (int i = 0; i < 4; i++) begin
            issue2(wa[i], wb[i], wp[i], wbcd[i]);
            wait_done(2);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("pending_results", EW'(exp0_q.size() + exp1_q.size() + exp2_q.size()), EW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
